// File: rtl/skip_step_counter_if.sv
// Control/status bundle for skip_step_counter: the master drives controls,
// and the counter (slave) returns its registered value and status pulses.
interface skip_step_counter_if #(
  parameter int unsigned WIDTH = 7
);
  logic             enable;
  logic             up_down;
  logic             oneshot;
  logic             skip_en;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] data;
  logic             wrap;
  logic             skipped;
  logic             done;

  modport master (
    output enable, up_down, oneshot, skip_en, load, load_value,
    input  data, wrap, skipped, done
  );

  modport slave (
    input  enable, up_down, oneshot, skip_en, load, load_value,
    output data, wrap, skipped, done
  );
endinterface

// File: rtl/skip_step_counter.sv
// Parametrised up/down step counter that never lands on SKIP_VAL, with
// parallel load, one-shot stop at the modulus boundary and status pulses.
module skip_step_counter #(
  parameter int unsigned      WIDTH    = 7,
  parameter logic [WIDTH-1:0] STEP     = WIDTH'(2),
  parameter logic [WIDTH-1:0] SKIP_VAL = WIDTH'(7),
  parameter logic [WIDTH-1:0] INIT_VAL = '1
) (
  input logic                clock,
  input logic                reset,
  skip_step_counter_if.slave bus
);

  typedef enum logic {S_RUN = 1'b0, S_DONE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             wrap_q, wrap_d;
  logic             skipped_q, skipped_d;

  logic [WIDTH:0]   sum1, sum2;
  logic [WIDTH-1:0] n1, n2;
  logic             hit, wrap_cond;

  // Two-step move; bit WIDTH of each sum is the carry (up) or borrow (down).
  always_comb begin
    if (bus.up_down) sum1 = {1'b0, data_q} + {1'b0, STEP};
    else             sum1 = {1'b0, data_q} - {1'b0, STEP};
    n1  = sum1[WIDTH-1:0];
    hit = bus.skip_en && (n1 == SKIP_VAL);
    if (bus.up_down) sum2 = {1'b0, n1} + {1'b0, STEP};
    else             sum2 = {1'b0, n1} - {1'b0, STEP};
    // The second result is deliberately not re-checked against SKIP_VAL.
    n2        = hit ? sum2[WIDTH-1:0] : n1;
    wrap_cond = sum1[WIDTH] | (hit & sum2[WIDTH]);
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // Next-state logic: DONE is left only by load (or reset).
  always_comb begin
    state_d = state_q;
    if (bus.load)
      state_d = S_RUN;
    else if (state_q == S_RUN && bus.enable && bus.oneshot && wrap_cond)
      state_d = S_DONE;
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    data_d    = data_q;
    wrap_d    = 1'b0;
    skipped_d = 1'b0;
    if (bus.load) begin
      data_d = bus.load_value;
    end else if (state_q == S_RUN && bus.enable) begin
      if (bus.oneshot && wrap_cond) begin
        wrap_d = 1'b1;
      end else begin
        data_d    = n2;
        wrap_d    = wrap_cond;
        skipped_d = hit;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_q    <= INIT_VAL;
      wrap_q    <= 1'b0;
      skipped_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      wrap_q    <= wrap_d;
      skipped_q <= skipped_d;
    end
  end

  assign bus.data    = data_q;
  assign bus.wrap    = wrap_q;
  assign bus.skipped = skipped_q;
  assign bus.done    = (state_q == S_DONE);

endmodule

// File: tb/tb_skip_step_counter.sv
// Scoreboarded directed bench for skip_step_counter (default and 4-bit builds).
module tb_skip_step_counter;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  skip_step_counter_if #(.WIDTH(7)) b0 ();
  skip_step_counter_if #(.WIDTH(4)) b1 ();

  skip_step_counter #(.WIDTH(7)) dut0 (
    .clock(clock), .reset(reset), .bus(b0.slave)
  );
  skip_step_counter #(
    .WIDTH(4), .STEP(4'd3), .SKIP_VAL(4'd0), .INIT_VAL(4'd15)
  ) dut1 (
    .clock(clock), .reset(reset), .bus(b1.slave)
  );

  typedef struct {
    int    dut;
    int    data;
    bit    wrap;
    bit    skp;
    bit    done;
    string tag;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   watch7   = 1'b0;
  bit   seen7    = 1'b0;

  // Monitor: one expected entry per edge, compared just after the edge.
  exp_t        e;
  logic [31:0] ad;
  logic        aw, as_, adn;
  always @(posedge clock) begin
    #1;
    if (watch7 && b0.data == 7'd7) seen7 = 1'b1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.dut == 0) begin
        ad = 32'(b0.data); aw = b0.wrap; as_ = b0.skipped; adn = b0.done;
      end else begin
        ad = 32'(b1.data); aw = b1.wrap; as_ = b1.skipped; adn = b1.done;
      end
      checks++;
      if (ad !== 32'(e.data) || aw !== e.wrap || as_ !== e.skp || adn !== e.done) begin
        failures++;
        $display("FAIL %s: got data=%0d wrap=%b skipped=%b done=%b, want data=%0d wrap=%b skipped=%b done=%b",
                 e.tag, ad, aw, as_, adn, e.data, e.wrap, e.skp, e.done);
      end
    end
  end

  task automatic tick0(input int d, input bit w, input bit s, input bit dn, input string tag);
    q.push_back('{dut:0, data:d, wrap:w, skp:s, done:dn, tag:tag});
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic tick1(input int d, input bit w, input bit s, input bit dn, input string tag);
    q.push_back('{dut:1, data:d, wrap:w, skp:s, done:dn, tag:tag});
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic ctl0(input bit en, input bit ud, input bit os, input bit se,
                      input bit ld, input int lv);
    b0.enable = en; b0.up_down = ud; b0.oneshot = os; b0.skip_en = se;
    b0.load = ld; b0.load_value = 7'(lv);
  endtask

  initial begin
    reset = 1'b0;
    ctl0(0, 0, 0, 0, 0, 0);
    b1.enable = 0; b1.up_down = 0; b1.oneshot = 0; b1.skip_en = 0;
    b1.load = 0; b1.load_value = '0;

    tick0(127, 0, 0, 0, "reset_state");

    // Free-running down count with skip of 7 and wrap at the bottom.
    reset = 1'b1;
    ctl0(1, 0, 0, 1, 0, 0);
    watch7 = 1'b1;
    for (int v = 125; v >= 9; v -= 2) tick0(v, 0, 0, 0, "down_run");
    tick0(5, 0, 1, 0, "down_skip_9_to_5");
    tick0(3, 0, 0, 0, "down_3");
    tick0(1, 0, 0, 0, "down_1");
    tick0(127, 1, 0, 0, "down_wrap");
    watch7 = 1'b0;
    checks++;
    if (seen7 !== 1'b0) begin
      failures++;
      $display("FAIL never_seven: got seen7=%b, want 0", seen7);
    end

    // One-shot stop at the boundary, exit only by load.
    ctl0(1, 0, 0, 1, 1, 3);
    tick0(3, 0, 0, 0, "load3_over_enable");
    ctl0(1, 0, 1, 1, 0, 0);
    tick0(1, 0, 0, 0, "oneshot_to_1");
    tick0(1, 1, 0, 1, "oneshot_done");
    tick0(1, 0, 0, 1, "done_hold_a");
    tick0(1, 0, 0, 1, "done_hold_b");
    ctl0(1, 0, 0, 1, 0, 0);
    tick0(1, 0, 0, 1, "done_oneshot_cleared");
    ctl0(1, 0, 0, 1, 1, 20);
    tick0(20, 0, 0, 0, "done_exit_load20");
    ctl0(1, 0, 0, 1, 0, 0);
    tick0(18, 0, 0, 0, "resume_18");
    tick0(16, 0, 0, 0, "resume_16");

    // Up mode.
    ctl0(1, 1, 0, 1, 1, 1);
    tick0(1, 0, 0, 0, "up_load1");
    ctl0(1, 1, 0, 1, 0, 0);
    tick0(3, 0, 0, 0, "up_3");
    tick0(5, 0, 0, 0, "up_5");
    tick0(9, 0, 1, 0, "up_skip_5_to_9");
    tick0(11, 0, 0, 0, "up_11");
    ctl0(1, 1, 0, 1, 1, 127);
    tick0(127, 0, 0, 0, "up_load127");
    ctl0(1, 1, 0, 1, 0, 0);
    tick0(1, 1, 0, 0, "up_wrap");
    ctl0(1, 1, 0, 0, 1, 5);
    tick0(5, 0, 0, 0, "up_load5");
    ctl0(1, 1, 0, 0, 0, 0);
    tick0(7, 0, 0, 0, "noskip_7");
    tick0(9, 0, 0, 0, "noskip_9");

    // Priority and hold.
    ctl0(1, 1, 0, 0, 1, 40);
    tick0(40, 0, 0, 0, "load_beats_enable");
    ctl0(0, 1, 0, 1, 0, 0);
    tick0(40, 0, 0, 0, "hold_1");
    tick0(40, 0, 0, 0, "hold_2");
    tick0(40, 0, 0, 0, "hold_3");
    reset = 1'b0;
    ctl0(1, 1, 0, 1, 1, 50);
    tick0(127, 0, 0, 0, "reset_beats_load");
    reset = 1'b1;

    // Reset mid-run, then load of the skip value itself.
    ctl0(1, 0, 0, 1, 1, 45);
    tick0(45, 0, 0, 0, "load45");
    ctl0(1, 0, 0, 1, 0, 0);
    tick0(43, 0, 0, 0, "mid_43");
    tick0(41, 0, 0, 0, "mid_41");
    reset = 1'b0;
    tick0(127, 0, 0, 0, "reset_mid_run");
    reset = 1'b1;
    ctl0(0, 0, 0, 1, 1, 7);
    tick0(7, 0, 0, 0, "load_skip_val");
    ctl0(1, 0, 0, 1, 0, 0);
    tick0(5, 0, 0, 0, "step_from_7");
    ctl0(0, 0, 0, 0, 0, 0);

    // 4-bit build: STEP=3, SKIP_VAL=0, counting down from 15.
    tick1(15, 0, 0, 0, "w4_idle");
    b1.enable = 1; b1.up_down = 0; b1.skip_en = 1;
    tick1(12, 0, 0, 0, "w4_12");
    tick1(9, 0, 0, 0, "w4_9");
    tick1(6, 0, 0, 0, "w4_6");
    tick1(3, 0, 0, 0, "w4_3");
    tick1(13, 1, 1, 0, "w4_skip0_wrap");
    tick1(10, 0, 0, 0, "w4_10");
    b1.enable = 0;

    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clock);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
